clk_sel_seq: RTL and testbench
==============================

CLK_SEL_SEQ -- requirements
Module: clk_sel_seq

Interface
REQ-001: Parameter SETTLE, default 4, SHALL set settle cycles per phase (legal 1..15; 0 SHALL behave as 1).
REQ-002: Parameter SEL_RST, default 2'b00, SHALL set the select value loaded on reset.
REQ-003: CP  input  1  SHALL be the single clock; all state updates on posedge CP.
REQ-004: CD  input  1  SHALL be the asynchronous, active-high reset.
REQ-005: REQ_VALID  input  1  SHALL flag a clock-source switch request.
REQ-006: REQ_SEL  input  2  SHALL carry the requested source index, sampled on acceptance.
REQ-007: REQ_READY  output  1  SHALL flag that a request can be accepted this cycle.
REQ-008: S  output  2  SHALL drive the {S1,S0} select of the downstream 4:1 clock mux.
REQ-009: GATE_EN  output  1  SHALL enable the downstream clock gate; 0 = muxed clock blocked.
REQ-010: BUSY  output  1  SHALL be high in every state except IDLE.
REQ-011: DONE  output  1  SHALL pulse high for exactly one cycle on switch completion.

Function
REQ-012: The FSM SHALL have states INIT, IDLE, WAIT_OFF, WAIT_ON. All outputs SHALL be registered.
REQ-013: INIT SHALL hold GATE_EN=0 for SETTLE cycles, then enter IDLE with GATE_EN=1 and REQ_READY=1. DONE SHALL NOT pulse.
REQ-014: REQ_READY SHALL be 1 only in IDLE. A request SHALL be accepted at a posedge with REQ_VALID=1 and REQ_READY=1 (acceptance edge k).
REQ-015: At edge k: REQ_SEL latched internally, GATE_EN<=0, REQ_READY<=0, counter loaded, state<=WAIT_OFF.
REQ-016: At edge k+SETTLE: S<=latched select, counter reloaded, state<=WAIT_ON. S SHALL change only while GATE_EN=0.
REQ-017: At edge k+2*SETTLE: GATE_EN<=1, DONE<=1, REQ_READY<=1, state<=IDLE. DONE SHALL clear at the next edge.
REQ-018: Total request-to-DONE latency SHALL be 2*SETTLE cycles. A new request SHALL be acceptable on the cycle DONE is high.
REQ-019: REQ_VALID and REQ_SEL changes while REQ_READY=0 SHALL be ignored. No request SHALL be queued.
REQ-020: The settle counter SHALL be 4 bits, count down, and reload on each phase entry. It SHALL never wrap below 0.
REQ-021: A request whose REQ_SEL equals current S SHALL run the full sequence (default build; see REQ-025).
REQ-022: GATE_EN and S SHALL never change on the same edge.

Reset
REQ-023: While CD=1, and immediately on CD assertion (asynchronous, including mid-sequence), outputs SHALL be: S=SEL_RST, GATE_EN=0, REQ_READY=0, BUSY=1, DONE=0, state=INIT, counter=SETTLE, latched select=SEL_RST.
REQ-024: After CD deasserts, the block SHALL run INIT (REQ-013) before accepting requests.

Configuration
REQ-025: Macro CLK_SEL_SEQ_SAME_SKIP_EN defined: a request with REQ_SEL==S SHALL NOT drop GATE_EN or change S. DONE SHALL pulse at k+1, and REQ_READY SHALL be 1 at k+1. Undefined: REQ-021 applies.

Verification
REQ-026: SETTLE=4, SEL_RST=0; CD pulse then release -> GATE_EN=0 for 4 cycles, then GATE_EN=1 and REQ_READY=1; S=0 throughout; no DONE.
REQ-027: Request REQ_SEL=2 at edge k -> GATE_EN=0 at k, S=2 at k+4, GATE_EN=1 with a single-cycle DONE at k+8; BUSY high k..k+7.
REQ-028: REQ_VALID held with REQ_SEL toggling 1/3 during a sequence -> ignored; the next acceptance occurs on the DONE cycle with the value present then.
REQ-029: CD asserted at k+5 of a 0->3 switch -> S=0 and GATE_EN=0 asynchronously; after release, INIT runs and S stays 0.
REQ-030: Request REQ_SEL=S -> without macro, full 8-cycle sequence; with CLK_SEL_SEQ_SAME_SKIP_EN, GATE_EN stays 1 and DONE at k+1.
REQ-031: Assertion across all tests: S changes only while GATE_EN=0; GATE_EN and S never change on the same edge; DONE is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/clk_sel_seq_if.sv
// ---------------------------------------------------------------------------
// clk_sel_seq_if
//
// Purpose: bundles the request handshake and the clock-mux control outputs of
// clk_sel_seq so the sequencer and its requester share one connection.
//
// Signals:
//   REQ_VALID  requester -> sequencer  switch request present
//   REQ_SEL    requester -> sequencer  requested source index (2 bits)
//   REQ_READY  sequencer -> requester  request can be accepted this cycle
//   S          sequencer -> mux        {S1,S0} select of the 4:1 clock mux
//   GATE_EN    sequencer -> gate       1 = muxed clock passes, 0 = blocked
//   BUSY       sequencer -> requester  high whenever the sequencer is not idle
//   DONE       sequencer -> requester  one-cycle pulse when a switch completes
//
// Modports:
//   master  requester side (drives REQ_VALID/REQ_SEL)
//   slave   sequencer side (clk_sel_seq)
// ---------------------------------------------------------------------------
interface clk_sel_seq_if;
  logic       REQ_VALID;
  logic [1:0] REQ_SEL;
  logic       REQ_READY;
  logic [1:0] S;
  logic       GATE_EN;
  logic       BUSY;
  logic       DONE;

  modport master (
    output REQ_VALID,
    output REQ_SEL,
    input  REQ_READY,
    input  S,
    input  GATE_EN,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  REQ_VALID,
    input  REQ_SEL,
    output REQ_READY,
    output S,
    output GATE_EN,
    output BUSY,
    output DONE
  );
endinterface

// File: rtl/clk_sel_seq.sv
// ---------------------------------------------------------------------------
// clk_sel_seq
//
// Purpose: glitch-free clock-source switch sequencer. It drives the select of
// a downstream 4:1 clock mux and the enable of the clock gate that follows
// it. A switch first blocks the gate, waits SETTLE cycles, changes the
// select, waits another SETTLE cycles and only then reopens the gate, so the
// select never moves while the muxed clock is visible downstream.
//
// Parameters:
//   SETTLE   settle cycles per phase, 1..15 (0 is treated as 1)
//   SEL_RST  select value applied during and after reset
//
// Ports:
//   CP   clock, all state changes on its rising edge
//   CD   asynchronous active-high reset
//   bus  clk_sel_seq_if.slave: REQ_VALID/REQ_SEL in, REQ_READY/S/GATE_EN/
//        BUSY/DONE out (all outputs come straight from flops)
//
// Build option:
//   CLK_SEL_SEQ_SAME_SKIP_EN  when defined, a request for the source that is
//   already selected completes in one cycle without touching GATE_EN or S.
//   When undefined, such a request runs the full block/switch/unblock
//   sequence like any other.
// ---------------------------------------------------------------------------
module clk_sel_seq #(
  parameter int unsigned SETTLE  = 4,
  parameter logic [1:0]  SEL_RST = 2'b00
) (
  input  logic          CP,
  input  logic          CD,
  clk_sel_seq_if.slave  bus
);

  // Zero would make a phase end before it starts, so it is clamped to one.
  localparam logic [3:0] SETTLE_EFF = (SETTLE == 0) ? 4'd1 : 4'(SETTLE);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    IDLE     = 2'd1,
    WAIT_OFF = 2'd2,
    WAIT_ON  = 2'd3
  } state_t;

  state_t     state_q;
  logic [3:0] settleCnt_q;
  logic [1:0] selLatched_q;
  logic [1:0] s_q;
  logic       gateEn_q;
  logic       reqReady_q;
  logic       busy_q;
  logic       done_q;

  logic       accept;
  logic       sameSkip;

  assign accept = bus.REQ_VALID && reqReady_q;

  // A same-source request may bypass the gate/select phases only in the
  // skip build; otherwise it is indistinguishable from a real switch.
`ifdef CLK_SEL_SEQ_SAME_SKIP_EN
  assign sameSkip = (bus.REQ_SEL == s_q);
`else
  assign sameSkip = 1'b0;
`endif

  // Sequencer. The settle counter is loaded with SETTLE_EFF on entry to each
  // timed phase and the phase ends on the edge where it reads 1, which makes
  // every phase exactly SETTLE_EFF edges long. It only decrements while it
  // is above 1, so it can never wrap. The skip path enters WAIT_ON with a
  // count of 1 so completion (DONE, REQ_READY) lands on the very next edge
  // with GATE_EN still high and S untouched.
  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      state_q      <= INIT;
      settleCnt_q  <= SETTLE_EFF;
      selLatched_q <= SEL_RST;
      s_q          <= SEL_RST;
      gateEn_q     <= 1'b0;
      reqReady_q   <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        INIT: begin
          if (settleCnt_q <= 4'd1) begin
            state_q    <= IDLE;
            gateEn_q   <= 1'b1;
            reqReady_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            settleCnt_q <= settleCnt_q - 4'd1;
          end
        end

        IDLE: begin
          if (accept) begin
            selLatched_q <= bus.REQ_SEL;
            reqReady_q   <= 1'b0;
            busy_q       <= 1'b1;
            if (sameSkip) begin
              state_q     <= WAIT_ON;
              settleCnt_q <= 4'd1;
            end else begin
              state_q     <= WAIT_OFF;
              settleCnt_q <= SETTLE_EFF;
              gateEn_q    <= 1'b0;
            end
          end
        end

        WAIT_OFF: begin
          if (settleCnt_q <= 4'd1) begin
            state_q     <= WAIT_ON;
            settleCnt_q <= SETTLE_EFF;
            s_q         <= selLatched_q;
          end else begin
            settleCnt_q <= settleCnt_q - 4'd1;
          end
        end

        WAIT_ON: begin
          if (settleCnt_q <= 4'd1) begin
            state_q    <= IDLE;
            gateEn_q   <= 1'b1;
            reqReady_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            settleCnt_q <= settleCnt_q - 4'd1;
          end
        end

        default: begin
          state_q     <= INIT;
          settleCnt_q <= SETTLE_EFF;
          gateEn_q    <= 1'b0;
          reqReady_q  <= 1'b0;
          busy_q      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.REQ_READY = reqReady_q;
  assign bus.S         = s_q;
  assign bus.GATE_EN   = gateEn_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;

endmodule

// File: tb/tb_clk_sel_seq.sv
// ---------------------------------------------------------------------------
// tb_clk_sel_seq
//
// Purpose: directed self-checking bench for clk_sel_seq with SETTLE=4 and
// SEL_RST=0. Expected values are written out per cycle from the switching
// timeline (gate drops at k, select moves at k+4, gate returns with DONE at
// k+8). A negedge monitor checks that S only moves while the gate is closed
// and that DONE never lasts two cycles.
// Build option exercised when defined: CLK_SEL_SEQ_SAME_SKIP_EN.
// ---------------------------------------------------------------------------
module tb_clk_sel_seq;

  logic cp = 1'b0;
  logic cd;
  int   total = 0;
  int   bad   = 0;

  clk_sel_seq_if bus();

  clk_sel_seq #(
    .SETTLE  (4),
    .SEL_RST (2'b00)
  ) dut (
    .CP  (cp),
    .CD  (cd),
    .bus (bus)
  );

  // 10-time-unit clock.
  always #5 cp = ~cp;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [1:0] observed,
                             input logic [1:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compares every DUT output against the expected cycle values.
  task automatic checkState(input string tag, input logic [1:0] eS,
                            input logic eGate, input logic eReady,
                            input logic eBusy, input logic eDone);
    checkOutput({tag, ".S"},         bus.S,                  eS);
    checkOutput({tag, ".GATE_EN"},   {1'b0, bus.GATE_EN},    {1'b0, eGate});
    checkOutput({tag, ".REQ_READY"}, {1'b0, bus.REQ_READY},  {1'b0, eReady});
    checkOutput({tag, ".BUSY"},      {1'b0, bus.BUSY},       {1'b0, eBusy});
    checkOutput({tag, ".DONE"},      {1'b0, bus.DONE},       {1'b0, eDone});
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] sel);
    bus.REQ_VALID = valid;
    bus.REQ_SEL   = sel;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  // Edges k+1..k+9 of an accepted switch from oldSel to newSel.
  task automatic finishSwitch(input logic [1:0] newSel, input logic [1:0] oldSel,
                              input string tag);
    for (int j = 1; j <= 8; j++) begin
      tick();
      checkState($sformatf("%s@k+%0d", tag, j), (j >= 4) ? newSel : oldSel,
                 j == 8, j == 8, j < 8, j == 8);
    end
    tick();
    checkState({tag, "@k+9"}, newSel, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic runSwitch(input logic [1:0] newSel, input logic [1:0] oldSel,
                           input string tag);
    applyStimulus(1'b1, newSel);
    tick();
    applyStimulus(1'b0, newSel);
    checkState({tag, "@k"}, oldSel, 1'b0, 1'b0, 1'b1, 1'b0);
    finishSwitch(newSel, oldSel, tag);
  endtask

  // Reset release followed by the INIT settle window.
  task automatic runInit(input string tag);
    cd = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      checkState($sformatf("%s@%0d", tag, j), 2'd0, j == 4, j == 4, j < 4, 1'b0);
    end
  endtask

  // Edge-to-edge safety monitor, sampled on the falling edge.
  logic [1:0] prevS;
  logic       prevGate;
  logic       prevDone;
  logic       prevOk = 1'b0;

  always @(negedge cp) begin
    if (!cd && prevOk) begin
      if (bus.S !== prevS) begin
        checkOutput("mon.s_move_gate_before", {1'b0, prevGate},    2'b00);
        checkOutput("mon.s_move_gate_after",  {1'b0, bus.GATE_EN}, 2'b00);
      end
      if (prevDone)
        checkOutput("mon.done_single", {1'b0, bus.DONE}, 2'b00);
    end
    prevS    = bus.S;
    prevGate = bus.GATE_EN;
    prevDone = bus.DONE;
    prevOk   = !cd;
  end

  initial begin
    cd = 1'b1;
    applyStimulus(1'b0, 2'd0);

    // Asynchronous reset values, before any clock edge and while held.
    #2;
    checkState("reset_async", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkState("reset_held", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // INIT: gate closed for 4 cycles, then idle and ready.
    runInit("init");
    tick();
    checkState("idle", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Plain switch 0 -> 2.
    runSwitch(2'd2, 2'd0, "sw0to2");

    // Request held during a 2 -> 1 switch with REQ_SEL toggling 3/1; the
    // toggles must be ignored.
    applyStimulus(1'b1, 2'd1);
    tick();
    checkState("hold@k", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(1'b1, (j % 2 == 1) ? 2'd3 : 2'd1);
      tick();
      checkState($sformatf("hold@k+%0d", j), (j >= 4) ? 2'd1 : 2'd2,
                 j == 8, j == 8, j < 8, j == 8);
    end
    // DONE cycle: the value present now is accepted on the next edge.
    applyStimulus(1'b1, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd3);
    checkState("donecyc@k", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    finishSwitch(2'd3, 2'd1, "donecyc");

    // Request for the source already selected.
`ifdef CLK_SEL_SEQ_SAME_SKIP_EN
    applyStimulus(1'b1, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd3);
    checkState("same@k", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkState("same@k+1", 2'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkState("same@k+2", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    runSwitch(2'd3, 2'd3, "same");
`endif

    // Back to 0, then start 0 -> 3 and reset it at k+5.
    runSwitch(2'd0, 2'd3, "sw3to0");
    applyStimulus(1'b1, 2'd3);
    tick();
    applyStimulus(1'b0, 2'd3);
    for (int j = 1; j <= 5; j++) tick();
    checkState("abort@k+5", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    cd = 1'b1;
    #1;
    checkState("abort_async", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkState("abort_held", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    runInit("reinit");
    tick();
    checkState("reinit_idle", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
